// File: rtl/erasable_parity_writer_if.sv
// Erasable-memory write port bundle: request side (write lines, S address, control)
// and memory side (G bus, address, strobes).
interface erasable_parity_writer_if;
    logic        GOJAM;
    logic        WR_REQ;
    logic [14:0] WL_n;
    logic [11:0] S;
    logic [15:0] G_IN;
    logic        CLR_ALARM;
    logic [15:0] G_OUT;
    logic [11:0] MADDR;
    logic        MWR;
    logic        MRD;
    logic        BUSY;
    logic        DONE;
    logic        PAR_FAIL;

    modport slave (
        input  GOJAM, WR_REQ, WL_n, S, G_IN, CLR_ALARM,
        output G_OUT, MADDR, MWR, MRD, BUSY, DONE, PAR_FAIL
    );

    modport master (
        output GOJAM, WR_REQ, WL_n, S, G_IN, CLR_ALARM,
        input  G_OUT, MADDR, MWR, MRD, BUSY, DONE, PAR_FAIL
    );
endinterface

// File: rtl/erasable_parity_writer.sv
// Erasable write path: latches ~WL_n and S, appends odd-parity G16, strobes MWR.
// Define PARWR_READBACK_EN to add settle/readback/odd-parity check with sticky PAR_FAIL.
module erasable_parity_writer #(
    parameter int unsigned WRITE_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                           SIM_CLK,
    input  logic                           SIM_RST,
    erasable_parity_writer_if.slave        bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PARGEN = 3'd1,
`ifdef PARWR_READBACK_EN
        SETTLE = 3'd3,
        READ   = 3'd4,
        CHECK  = 3'd5,
`endif
        WRITE  = 3'd2
    } state_t;

    localparam logic [3:0] WCNT_LOAD = 4'(WRITE_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [14:0] data_q;
    logic [15:0] g_out_q;
    logic [11:0] maddr_q;
    logic        done_q, done_d;
    logic        accept;
    logic        gen_word;

`ifdef PARWR_READBACK_EN
    localparam logic [2:0] SCNT_LOAD = 3'(SETTLE_CYCLES);

    logic [2:0]  scnt_q, scnt_d;
    logic        par_fail_q;
    logic        fail_set;
`endif

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        done_d   = 1'b0;
        accept   = 1'b0;
        gen_word = 1'b0;
`ifdef PARWR_READBACK_EN
        scnt_d   = scnt_q;
        fail_set = 1'b0;
`endif
        // GOJAM overrides everything: no accept, no DONE, no alarm update
        if (bus.GOJAM) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.WR_REQ) begin
                        accept  = 1'b1;
                        state_d = PARGEN;
                    end
                end
                PARGEN: begin
                    gen_word = 1'b1;
                    wcnt_d   = WCNT_LOAD;
                    state_d  = WRITE;
                end
                WRITE: begin
                    if (wcnt_q == 4'd1) begin
`ifdef PARWR_READBACK_EN
                        if (SETTLE_CYCLES == 0) begin
                            state_d = READ;
                        end else begin
                            state_d = SETTLE;
                            scnt_d  = SCNT_LOAD;
                        end
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        wcnt_d = wcnt_q - 4'd1;
                    end
                end
`ifdef PARWR_READBACK_EN
                SETTLE: begin
                    if (scnt_q == 3'd1) begin
                        state_d = READ;
                    end else begin
                        scnt_d = scnt_q - 3'd1;
                    end
                end
                READ: begin
                    state_d = CHECK;
                end
                CHECK: begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    fail_set = (~^bus.G_IN) || (bus.G_IN != g_out_q);
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            data_q  <= '0;
            g_out_q <= '0;
            maddr_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            done_q  <= done_d;
            if (accept) begin
                data_q  <= ~bus.WL_n;
                maddr_q <= bus.S;
            end
            if (gen_word) begin
                g_out_q <= {~^data_q, data_q};
            end
        end
    end

`ifdef PARWR_READBACK_EN
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            scnt_q     <= '0;
            par_fail_q <= 1'b0;
        end else begin
            scnt_q <= scnt_d;
            if (!bus.GOJAM) begin
                if (fail_set) begin
                    par_fail_q <= 1'b1;
                end else if (bus.CLR_ALARM) begin
                    par_fail_q <= 1'b0;
                end
            end
        end
    end

    assign bus.MRD      = (state_q == READ);
    assign bus.PAR_FAIL = par_fail_q;
`else
    logic unused_readback;
    assign unused_readback = ^{bus.G_IN, bus.CLR_ALARM, 3'(SETTLE_CYCLES)};

    assign bus.MRD      = 1'b0;
    assign bus.PAR_FAIL = 1'b0;
`endif

    assign bus.G_OUT = g_out_q;
    assign bus.MADDR = maddr_q;
    assign bus.MWR   = (state_q == WRITE);
    assign bus.BUSY  = (state_q != IDLE);
    assign bus.DONE  = done_q;

endmodule

// File: tb/tb_erasable_parity_writer.sv
// Directed bench for erasable_parity_writer; readback checks are built when
// PARWR_READBACK_EN is defined.
module tb_erasable_parity_writer;
    localparam int unsigned WC = 4;
    localparam int unsigned SC = 1;
`ifdef PARWR_READBACK_EN
    localparam int unsigned LAT          = 9;
    localparam logic [31:0] B2B_MWR_EXP  = 32'h0000_783C;
    localparam logic [31:0] B2B_DONE_EXP = 32'h0004_0200;
`else
    localparam int unsigned LAT          = 6;
    localparam logic [31:0] B2B_MWR_EXP  = 32'h0000_0F3C;
    localparam logic [31:0] B2B_DONE_EXP = 32'h0000_1040;
`endif

    logic        SIM_CLK = 1'b0;
    logic        SIM_RST;
    logic [15:0] mem_word = '0;
    logic        bad_mem;
    int          tests = 0;
    int          fails = 0;

    erasable_parity_writer_if bus();

    erasable_parity_writer #(
        .WRITE_CYCLES (WC),
        .SETTLE_CYCLES(SC)
    ) dut (
        .SIM_CLK(SIM_CLK),
        .SIM_RST(SIM_RST),
        .bus    (bus)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    // memory model: stores what is strobed, optionally returns all-zero on read
    always @(posedge SIM_CLK) if (bus.MWR) mem_word <= bus.G_OUT;
    assign bus.G_IN = bad_mem ? 16'h0000 : mem_word;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge SIM_CLK);
        #1;
    endtask

    task automatic do_write(input logic [14:0] data, input logic [11:0] addr,
                            input logic [15:0] exp_word, input string tag);
        int first_mwr = -1;
        int n_mwr = 0;
        int done_cyc = -1;
        int unstable = 0;
        logic busy_at_done = 1'b1;
        bus.WL_n   = ~data;
        bus.S      = addr;
        bus.WR_REQ = 1'b1;
        for (int i = 1; i <= 40 && done_cyc < 0; i++) begin
            step();
            if (i == 1) begin
                bus.WR_REQ = 1'b0;
                bus.WL_n   = '1;
                bus.S      = '0;
            end
            if (bus.MWR) begin
                if (first_mwr < 0) first_mwr = i;
                n_mwr++;
                if (bus.G_OUT !== exp_word || bus.MADDR !== addr) unstable++;
            end
            if (bus.DONE) begin
                done_cyc     = i;
                busy_at_done = bus.BUSY;
            end
        end
        check({tag, "_gout"},      32'(bus.G_OUT), 32'(exp_word));
        check({tag, "_maddr"},     32'(bus.MADDR), 32'(addr));
        check({tag, "_mwr_start"}, first_mwr, 2);
        check({tag, "_mwr_len"},   n_mwr, WC);
        check({tag, "_done_cyc"},  done_cyc, LAT);
        check({tag, "_stable"},    unstable, 0);
        check({tag, "_busy_done"}, 32'(busy_at_done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mwr_vec;
        logic [31:0] done_vec;
        logic [15:0] g_a, g_b;
        logic [11:0] a_a, a_b;
        int          stray;

        SIM_RST       = 1'b1;
        bad_mem       = 1'b0;
        bus.GOJAM     = 1'b0;
        bus.CLR_ALARM = 1'b0;
        bus.WR_REQ    = 1'b1;
        bus.WL_n      = 15'h0000;
        bus.S         = 12'hFFF;
        step();
        step();
        check("rst_gout",     32'(bus.G_OUT), 0);
        check("rst_maddr",    32'(bus.MADDR), 0);
        check("rst_mwr",      32'(bus.MWR), 0);
        check("rst_mrd",      32'(bus.MRD), 0);
        check("rst_busy",     32'(bus.BUSY), 0);
        check("rst_done",     32'(bus.DONE), 0);
        check("rst_par_fail", 32'(bus.PAR_FAIL), 0);
        SIM_RST    = 1'b0;
        bus.WR_REQ = 1'b0;
        step();
        check("rst_no_start", 32'(bus.BUSY), 0);

        do_write(15'h0000, 12'h123, 16'h8000, "w0");
        do_write(15'h0001, 12'h456, 16'h0001, "w1");
        do_write(15'h7FFF, 12'hABC, 16'h7FFF, "w7fff");
        do_write(15'h0003, 12'h001, 16'h8003, "w3");
        check("w_mrd_idle", 32'(bus.MRD), 0);
        check("w_par_fail", 32'(bus.PAR_FAIL), 0);

        // back-to-back with WR_REQ held high
        mwr_vec    = '0;
        done_vec   = '0;
        bus.WL_n   = ~15'h0003;
        bus.S      = 12'h0AA;
        bus.WR_REQ = 1'b1;
        for (int i = 1; i <= 2 * LAT; i++) begin
            step();
            if (i == 1) begin
                bus.WL_n = ~15'h7FFF;
                bus.S    = 12'h0BB;
            end
            if (i == LAT + 1) bus.WR_REQ = 1'b0;
            mwr_vec[i]  = bus.MWR;
            done_vec[i] = bus.DONE;
            if (i == 2) begin
                g_a = bus.G_OUT;
                a_a = bus.MADDR;
            end
            if (i == LAT + 2) begin
                g_b = bus.G_OUT;
                a_b = bus.MADDR;
            end
        end
        check("b2b_mwr_pattern",  mwr_vec, B2B_MWR_EXP);
        check("b2b_done_pattern", done_vec, B2B_DONE_EXP);
        check("b2b_word_a", 32'(g_a), 32'h8003);
        check("b2b_addr_a", 32'(a_a), 32'h0AA);
        check("b2b_word_b", 32'(g_b), 32'h7FFF);
        check("b2b_addr_b", 32'(a_b), 32'h0BB);

        // GOJAM during the second MWR cycle
        bus.WL_n   = ~15'h0001;
        bus.S      = 12'h321;
        bus.WR_REQ = 1'b1;
        step();
        bus.WR_REQ = 1'b0;
        step();
        step();
        check("gj_mwr2", 32'(bus.MWR), 1);
        bus.GOJAM = 1'b1;
        step();
        bus.GOJAM = 1'b0;
        check("gj_mwr_off", 32'(bus.MWR), 0);
        check("gj_busy",    32'(bus.BUSY), 0);
        check("gj_done",    32'(bus.DONE), 0);
        check("gj_gout",    32'(bus.G_OUT), 32'h0001);
        check("gj_maddr",   32'(bus.MADDR), 32'h321);
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.DONE || bus.MWR) stray++;
        end
        check("gj_no_done", stray, 0);

        // GOJAM together with WR_REQ in IDLE blocks the accept
        bus.GOJAM  = 1'b1;
        bus.WR_REQ = 1'b1;
        step();
        bus.GOJAM  = 1'b0;
        bus.WR_REQ = 1'b0;
        check("gj_req_busy", 32'(bus.BUSY), 0);
        step();
        check("gj_req_mwr", 32'(bus.MWR), 0);

        do_write(15'h5555, 12'h7E0, 16'hD555, "after_gj");

`ifdef PARWR_READBACK_EN
        bad_mem = 1'b1;
        do_write(15'h0000, 12'h010, 16'h8000, "rb_bad");
        check("rb_fail_set", 32'(bus.PAR_FAIL), 1);
        bad_mem = 1'b0;
        do_write(15'h0001, 12'h011, 16'h0001, "rb_good");
        check("rb_fail_sticky", 32'(bus.PAR_FAIL), 1);
        bus.CLR_ALARM = 1'b1;
        step();
        bus.CLR_ALARM = 1'b0;
        check("rb_fail_clr", 32'(bus.PAR_FAIL), 0);
        do_write(15'h0003, 12'h012, 16'h8003, "rb_echo");
        check("rb_echo_ok", 32'(bus.PAR_FAIL), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
